// File: rtl/adc_sequencer.sv
// adc_sequencer: round-robin SPI master for two ADCs sharing SCLK/SS, with a valid/ready sample output
module adc_sequencer #(
    parameter int NBITS = 16,
    parameter int DIV = 2,
    parameter int GAP = 4,
    parameter int CHBITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2**CHBITS-1:0] chan_mask,
    output logic                 sclk,
    output logic                 ss,
    output logic                 mosi,
    input  logic                 adc1_miso,
    input  logic                 adc2_miso,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHBITS-1:0]    out_chan,
    output logic [NBITS-1:0]     out_data1,
    output logic [NBITS-1:0]     out_data2,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);
    localparam int NCH = 2**CHBITS;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
    state_t state, state_n;
    logic [31:0] cnt, bitcnt;
    logic ph, last, go, start, sample, load, drop;
    logic [CHBITS-1:0] ch, ch_n;
    logic [NBITS-1:0] cmd, sr1, sr2;
    assign go = enable && |chan_mask;
    assign last = cnt == 32'(state == S_GAP ? GAP - 1 : DIV - 1);
    assign sample = state == S_SHIFT && last && !ph;
    assign load = state == S_SHIFT && last && ph && bitcnt == 32'(NBITS - 1);
    assign drop = load && out_valid && !out_ready;
    assign start = state_n == S_SETUP && state != S_SETUP;
    // Descending scan so the nearest set bit after the pointer wins; offset NCH wraps to the pointer itself.
    always_comb begin
        ch_n = ch;
        for (int i = NCH; i >= 1; i--)
            if (chan_mask[ch + CHBITS'(i)]) ch_n = ch + CHBITS'(i);
    end
    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = go ? S_SETUP : S_IDLE;
            S_SETUP: state_n = last ? S_SHIFT : S_SETUP;
            S_SHIFT: state_n = load ? S_HOLD : S_SHIFT;
            S_HOLD:  state_n = last ? S_GAP : S_HOLD;
            S_GAP:   state_n = last ? (go ? S_SETUP : S_IDLE) : S_GAP;
            default: state_n = S_IDLE;
        endcase
    end
    always_comb begin
        sclk = !(state == S_SHIFT && !ph);
        ss = !(state == S_SETUP || state == S_SHIFT || state == S_HOLD);
        mosi = (state == S_SETUP || state == S_SHIFT) && cmd[NBITS-1];
        busy = state != S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            bitcnt <= '0;
            ph <= 1'b0;
            ch <= '1;
            cmd <= '0;
            sr1 <= '0;
            sr2 <= '0;
            out_valid <= 1'b0;
            out_chan <= '0;
            out_data1 <= '0;
            out_data2 <= '0;
            overrun <= 1'b0;
        end else begin
            cnt <= (state == S_IDLE || last) ? '0 : cnt + 32'd1;
            ph <= state == S_SHIFT && (ph ^ last);
            bitcnt <= state == S_SHIFT ? bitcnt + 32'(last && ph) : '0;
            if (start)
                cmd <= NBITS'(ch_n) << (NBITS - CHBITS);
            else if (state == S_SHIFT && last && ph)
                cmd <= cmd << 1;
            if (start)
                ch <= ch_n;
            if (sample) begin
                sr1 <= {sr1[NBITS-2:0], adc1_miso};
                sr2 <= {sr2[NBITS-2:0], adc2_miso};
            end
            if (load && !drop) begin
                out_valid <= 1'b1;
                out_chan <= ch;
                out_data1 <= sr1;
                out_data2 <= sr2;
            end else if (out_ready)
                out_valid <= 1'b0;
            overrun <= drop || (overrun && !overrun_clr);
        end
    end
endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: table-driven, directed and randomized checks of adc_sequencer against a frame-position model
module tb_adc_sequencer;
    localparam int N = 16, D = 2, G = 4, CB = 2, NCH = 4;
    localparam int LD = D * (1 + 2 * N), SSL = D * (2 * N + 2), L = SSL + G;
    logic clk = 0, reset = 1, enable = 0, adc1_miso = 0, adc2_miso = 0, out_ready = 1, overrun_clr = 0;
    logic [NCH-1:0] chan_mask = 0;
    logic sclk, ss, mosi, out_valid, overrun, busy;
    logic [CB-1:0] out_chan;
    logic [N-1:0] out_data1, out_data2;
    logic enable2 = 0;
    logic sclk2, ss2, mosi2, valid2, ovr2, busy2;
    logic [1:0] chan2;
    logic [3:0] da2, db2;

    adc_sequencer dut (.clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .sclk(sclk), .ss(ss),
        .mosi(mosi), .adc1_miso(adc1_miso), .adc2_miso(adc2_miso), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_data1(out_data1), .out_data2(out_data2), .overrun(overrun),
        .overrun_clr(overrun_clr), .busy(busy));

    adc_sequencer #(.NBITS(4), .DIV(1), .GAP(1), .CHBITS(2)) dut2 (.clk(clk), .reset(reset), .enable(enable2),
        .chan_mask(4'b0001), .sclk(sclk2), .ss(ss2), .mosi(mosi2), .adc1_miso(1'b0), .adc2_miso(1'b0),
        .out_valid(valid2), .out_ready(1'b1), .out_chan(chan2), .out_data1(da2), .out_data2(db2), .overrun(ovr2),
        .overrun_clr(1'b0), .busy(busy2));

    always #5 clk = ~clk;

    int ntests = 0, nfail = 0, cyc = 0;
    int m_pos = -1, m_ptr = NCH - 1, m_chan = 0, m_ochan = 0;
    logic m_valid = 0, m_ovr = 0, rnd = 0;
    logic [N-1:0] m_w1 = 0, m_w2 = 0, m_d1 = 0, m_d2 = 0, w1_next = 0, w2_next = 0;

    typedef struct { logic [3:0] mask; logic [15:0] w1; logic [15:0] w2; int chan; } vec_t;
    vec_t tab[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int next_chan(input logic [NCH-1:0] m, input int p);
        for (int i = 1; i <= NCH; i++)
            if (m[CB'((p + i) % NCH)]) return (p + i) % NCH;
        return p;
    endfunction

    // Model advances one clock: frame position, round-robin pick, output register and overrun.
    task automatic model_edge();
        logic drop;
        drop = 0;
        if (reset) begin
            m_pos = -1; m_ptr = NCH - 1; m_valid = 0; m_ovr = 0; m_ochan = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            if (m_pos >= 0) m_pos++;
            if (m_pos == L) m_pos = -1;
            if (m_pos < 0 && enable && chan_mask != 0) begin
                m_pos = 0;
                m_chan = next_chan(chan_mask, m_ptr);
                m_ptr = m_chan;
                m_w1 = rnd ? N'($urandom) : w1_next;
                m_w2 = rnd ? N'($urandom) : w2_next;
            end
            if (m_pos == LD) begin
                if (m_valid && !out_ready) drop = 1;
                else begin
                    m_valid = 1; m_ochan = m_chan; m_d1 = m_w1; m_d2 = m_w2;
                end
            end else if (out_ready) m_valid = 0;
            m_ovr = drop || (m_ovr && !overrun_clr);
        end
    endtask

    task automatic compare_and_drive();
        int q, k;
        logic e_ss, e_sclk, e_mosi, low;
        q = m_pos - D;
        low = m_pos >= D && q < 2 * D * N && (q / D) % 2 == 0;
        k = m_pos < D ? 0 : q / (2 * D);
        e_ss = !(m_pos >= 0 && m_pos < SSL);
        e_sclk = !low;
        e_mosi = m_pos >= 0 && (m_pos < D || q < 2 * D * N) && k < CB && m_chan[CB-1-k];
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("ss", 32'(ss), 32'(e_ss));
        chk("mosi", 32'(mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'(m_pos >= 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("out_chan", 32'(out_chan), m_ochan);
        chk("out_data1", 32'(out_data1), 32'(m_d1));
        chk("out_data2", 32'(out_data2), 32'(m_d2));
        if (low) begin
            adc1_miso = m_w1[4'(N - 1 - k)];
            adc2_miso = m_w2[4'(N - 1 - k)];
        end else begin
            adc1_miso = 1'($urandom);
            adc2_miso = 1'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_and_drive();
    endtask

    task automatic wait_ss(input logic lvl, input string name);
        for (int i = 0; i < 200 && ss !== lvl; i++) tick();
        chk(name, 32'(ss === lvl), 32'd1);
    endtask

    task automatic wait_start();
        wait_ss(1'b1, "wait_ss_high");
        wait_ss(1'b0, "wait_ss_low");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && out_valid !== 1'b1; i++) tick();
        chk("wait_out_valid", 32'(out_valid === 1'b1), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, lowc, rises, per;
        logic psc;
        tab[0] = '{4'b0001, 16'hA5A5, 16'h5A5A, 0};
        tab[1] = '{4'b0001, 16'hA5A5, 16'h5A5A, 0};
        tab[2] = '{4'b1010, 16'h1234, 16'h8001, 1};
        tab[3] = '{4'b1010, 16'hFFFF, 16'h0000, 3};
        tab[4] = '{4'b1010, 16'h0F0F, 16'hF0F0, 1};
        tab[5] = '{4'b1010, 16'h8000, 16'h0001, 3};
        tab[6] = '{4'b0100, 16'hC3C3, 16'h3C3C, 2};
        tab[7] = '{4'b0100, 16'hDEAD, 16'hBEEF, 2};
        tab[8] = '{4'b1111, 16'h7E81, 16'h1818, 3};
        tab[9] = '{4'b1111, 16'h0001, 16'h8000, 0};
        reset = 1;
        tick();
        tick();
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data1", 32'(out_data1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 0;
        enable = 1;
        chan_mask = tab[0].mask;
        w1_next = tab[0].w1;
        w2_next = tab[0].w2;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            wait_start();
            if (i > 0) chk("frame_period", cyc - prev, L);
            prev = cyc;
            repeat (10) tick();
            if (i < 9) begin
                chan_mask = tab[i+1].mask;
                w1_next = tab[i+1].w1;
                w2_next = tab[i+1].w2;
            end
            wait_valid();
            chk("tab_chan", 32'(out_chan), tab[i].chan);
            chk("tab_data1", 32'(out_data1), 32'(tab[i].w1));
            chk("tab_data2", 32'(out_data2), 32'(tab[i].w2));
        end
        wait_start();
        repeat (20) tick();
        enable = 0;
        wait_valid();
        chk("stop_chan", 32'(out_chan), 32'd1);
        repeat (8) tick();
        chk("stop_ss", 32'(ss), 32'd1);
        chk("stop_busy", 32'(busy), 32'd0);
        chan_mask = 0;
        enable = 1;
        repeat (20) tick();
        chk("nomask_ss", 32'(ss), 32'd1);
        chk("nomask_sclk", 32'(sclk), 32'd1);
        chk("nomask_busy", 32'(busy), 32'd0);
        chan_mask = 4'b0110;
        w1_next = 16'h1357;
        w2_next = 16'h2468;
        wait_start();
        repeat (20) tick();
        reset = 1;
        tick();
        chk("midrst_ss", 32'(ss), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        reset = 0;
        wait_start();
        wait_valid();
        chk("midrst_restart_chan", 32'(out_chan), 32'd1);
        chk("midrst_restart_data", 32'(out_data1), 32'h1357);
        enable = 0;
        reset = 1;
        tick();
        reset = 0;
        chan_mask = 4'b0001;
        out_ready = 0;
        w1_next = 16'h1111;
        w2_next = 16'h2222;
        enable = 1;
        wait_start();
        repeat (10) tick();
        w1_next = 16'h3333;
        w2_next = 16'h4444;
        wait_valid();
        chk("bp_first", 32'(out_data1), 32'h1111);
        wait_start();
        repeat (10) tick();
        w1_next = 16'h7777;
        w2_next = 16'h8888;
        repeat (LD - 10) tick();
        chk("bp_ovr_second", 32'(overrun), 32'd1);
        chk("bp_held_second", 32'(out_data1), 32'h1111);
        wait_start();
        repeat (10) tick();
        w1_next = 16'h5555;
        w2_next = 16'h6666;
        repeat (LD - 10) tick();
        chk("bp_held_third", 32'(out_data1), 32'h1111);
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        chk("bp_ovr_clr", 32'(overrun), 32'd0);
        wait_start();
        repeat (10) tick();
        w1_next = 16'h9999;
        w2_next = 16'hAAAA;
        repeat (LD - 11) tick();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("same_cycle_valid", 32'(out_valid), 32'd1);
        chk("same_cycle_data", 32'(out_data1), 32'h5555);
        chk("same_cycle_ovr", 32'(overrun), 32'd0);
        wait_start();
        repeat (LD - 1) tick();
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        chk("clr_vs_set_ovr", 32'(overrun), 32'd1);
        chk("clr_vs_set_data", 32'(out_data1), 32'h5555);
        out_ready = 1;
        tick();
        chk("accept_clears_valid", 32'(out_valid), 32'd0);
        rnd = 1;
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom % 4) != 0;
            overrun_clr = ($urandom % 16) == 0;
            if ($urandom % 60 == 0) chan_mask = 4'($urandom);
            if ($urandom % 150 == 0) enable = !enable;
            reset = ($urandom % 1500) == 0;
            tick();
        end
        rnd = 0;
        reset = 0;
        enable = 0;
        enable2 = 1;
        for (int i = 0; i < 50 && ss2 !== 1'b0; i++) tick();
        lowc = 0;
        rises = 0;
        psc = sclk2;
        for (int i = 0; i < 50 && ss2 === 1'b0; i++) begin
            lowc++;
            tick();
            if (ss2 === 1'b0 && !psc && sclk2) rises++;
            psc = sclk2;
        end
        per = lowc;
        for (int i = 0; i < 50 && ss2 !== 1'b0; i++) begin
            per++;
            tick();
        end
        chk("small_ss_low_clocks", lowc, 10);
        chk("small_sclk_rises", rises, 4);
        chk("small_frame_period", per, 11);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
SPI master and scheduler for the two acquisition ADCs that share one SCLK/SS pair. It round-robins over the enabled mux channels and runs one frame per channel. Each frame shifts the channel index out on MOSI while capturing adc1_miso and adc2_miso in parallel. Each completed sample pair goes to the capture logic over a valid/ready interface.

Parameters:
NBITS, 16, bits per frame (frame length in SCLK periods); legal 4..32
DIV, 2, system clocks per SCLK half-period; legal >=1
GAP, 4, clocks SS is held high between frames; legal >=1
CHBITS, 2, width of channel index; number of channels = 2**CHBITS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run scheduler; sampled at frame start
chan_mask  in  2**CHBITS  enabled channels; bit n = channel n
sclk  out  1  SPI clock; idles high
ss  out  1  shared ADC select; active low
mosi  out  1  command bit to ADCs
adc1_miso  in  1  ADC1 data
adc2_miso  in  1  ADC2 data
out_valid  out  1  sample pair available
out_ready  in  1  consumer accepts when out_valid&&out_ready
out_chan  out  CHBITS  channel of sample pair
out_data1  out  NBITS  ADC1 frame, first bit received in MSB
out_data2  out  NBITS  ADC2 frame, same ordering
overrun  out  1  sticky: a completed frame was dropped
overrun_clr  in  1  clears overrun
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: sclk=1, ss=1, mosi=0, out_valid=0, out_chan=0, out_data1/2=0, overrun=0, busy=0, state=IDLE, current channel pointer=2**CHBITS-1 (so the first pick is the lowest set bit).
- States:
  - IDLE -> SETUP when enable=1 and chan_mask!=0. On that transition the next channel is latched: the first set bit of chan_mask strictly after the pointer, wrapping past the top.
  - SETUP: ss=0, sclk=1, mosi=channel MSB, for DIV clocks -> SHIFT.
  - SHIFT: NBITS bit periods. Each period is sclk=0 for DIV clocks, then sclk=1 for DIV clocks.
  - HOLD: ss=0, sclk=1, for DIV clocks -> GAP.
  - GAP: ss=1 for GAP clocks, then -> SETUP if enable=1 and chan_mask!=0, else -> IDLE.
- MOSI:
  - Updated on the clk where sclk goes 1->0.
  - Bit k of the frame = channel index bit (CHBITS-1-k) for k<CHBITS, else 0.
  - mosi returns to 0 in HOLD.
- MISO sampling: both MISO inputs are shifted into internal shift registers on the clk where sclk goes 0->1.
- Frame length: total = DIV + 2*DIV*NBITS + DIV + GAP clocks. Defaults give 72.
- Output load:
  - Happens on the clk entering HOLD. out_data1/2 and out_chan are loaded, and out_valid is set.
  - If out_valid=1 and out_ready=0 in that cycle: the new frame is dropped, the old data is held, and overrun is set.
  - If out_ready=1 in that same cycle: the old data is consumed and the new data is loaded; no overrun.
- Handshake: out_valid clears on the accept cycle unless a load coincides. Output data is stable while out_valid=1 and not accepted.
- overrun_clr clears overrun. If overrun_clr and a new overrun occur in the same cycle, overrun stays set.
- chan_mask and enable changes mid-frame have no effect until the next frame decision. Clearing enable completes the current frame, including its output load.
- reset mid-frame: next clock ss=1, sclk=1, all state as reset; any partial frame is discarded.

Test Plan:
- Single channel: chan_mask=0001, enable=1, ADC models return 0xA5A5/0x5A5A, out_ready=1 -> out_valid pulses with out_chan=0, data1=0xA5A5, data2=0x5A5A. Frames repeat every 72 clocks. MOSI frame = 00 followed by 14 zeros.
- Round robin: chan_mask=1010 -> out_chan sequence 1,3,1,3. MOSI leading bits 01,11,01,11. Change the mask to 0100 mid-frame -> the current frame completes, then only channel 2.
- Backpressure: out_ready=0 for three frames -> first sample held unchanged and overrun=1 after the second frame. overrun_clr -> overrun=0. Load and accept in the same cycle -> no overrun.
- Stop: enable dropped during SHIFT -> frame completes and loads, ss=1, busy=0, IDLE. chan_mask=0 with enable=1 -> stays IDLE, ss=1, sclk=1.
- Reset mid-SHIFT -> one clock later ss=1, sclk=1, out_valid=0. Restart begins at the lowest enabled channel.
- Timing check with DIV=1, NBITS=4, GAP=1: ss low for exactly 10 clocks, 4 rising sclk edges, frame period 11 clocks.
